// File: rtl/bit_pattern_scan_ctrl_pkg.sv
// Shared definitions for the bit pattern scan controller: FSM encoding,
// byte width and the default pattern length.
package bit_pattern_scan_ctrl_pkg;

    localparam int BYTE_W      = 8;
    localparam int PAT_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bit_pattern_scan_ctrl_matcher.sv
// Serial pattern matcher: keeps a history of the most recent bits and a fill
// level, and flags a hit combinationally in the cycle a bit is presented.
module pattern_shift_matcher
    import bit_pattern_scan_ctrl_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               din,
    input  logic               bit_vld,
    input  logic               clr,
    input  logic [LEN_W-1:0]   len,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic               overlap,
    output logic               hit
);

    localparam logic [LEN_W:0] FILL_MAX = (LEN_W + 1)'(PAT_MAX);

    logic [PAT_MAX-1:0] hist;
    logic [PAT_MAX-1:0] hist_n;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W:0]     fill_n;

    // fill is evaluated one bit wider so PAT_MAX+1 never wraps before the clamp
    always_comb begin
        hist_n   = {hist[PAT_MAX-2:0], din};
        fill_inc = {1'b0, fill} + 1'b1;
        fill_n   = (fill_inc > FILL_MAX) ? FILL_MAX : fill_inc;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = bit_vld && (len != '0) && (fill_n >= {1'b0, len}) &&
              (((hist_n ^ pattern) & mask) == '0);
    end

    // Non-overlap mode restarts the fill so the next match needs len fresh bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (bit_vld) begin
            hist <= hist_n;
            fill <= (hit && !overlap) ? '0 : fill_n[LEN_W-1:0];
        end
    end

endmodule

// File: rtl/bit_pattern_scan_ctrl.sv
// Byte-stream scan controller: accepts bytes, serializes them MSB first into
// the pattern matcher, counts matches and ends the scan on target or abort.
module bit_pattern_scan_ctrl
    import bit_pattern_scan_ctrl_pkg::*;
#(
    parameter int  PAT_MAX = PAT_MAX_DEF,
    parameter int  CNT_W   = 8,
    parameter int  POS_W   = 16,
    localparam int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [POS_W-1:0]   first_pos,
    output logic               first_vld,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = $clog2(BYTE_W);

    state_t             state;
    state_t             state_n;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [BYTE_W-1:0]  byte_q;
    logic [IDX_W-1:0]   bit_idx;
    logic [POS_W-1:0]   pos;
    logic               start_acc;
    logic               byte_acc;
    logic               feed;
    logic               hit;
    logic               tgt_hit;
    logic [CNT_W-1:0]   cnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : l;
    endfunction

    assign cnt_inc = sat_inc(match_count);
    assign tgt_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

    pattern_shift_matcher #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk     (clk),
        .rstn    (rstn),
        .din     (byte_q[bit_idx]),
        .bit_vld (feed),
        .clr     (start_acc),
        .len     (len_q),
        .pattern (pat_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Abort wins over a same-cycle hit for the transition; the hit is still counted below
    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        byte_acc  = 1'b0;
        feed      = 1'b0;
        busy      = (state != ST_IDLE);
        in_ready  = (state == ST_LOAD);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_n   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_n = ST_DONE;
                end else if (in_valid) begin
                    byte_acc = 1'b1;
                    state_n  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                feed = 1'b1;
                if (abort || tgt_hit) begin
                    state_n = ST_DONE;
                end else if (bit_idx == '0) begin
                    state_n = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Stage boundary: hit from the feed cycle becomes the registered match pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            byte_q      <= '0;
            bit_idx     <= '0;
            pos         <= '0;
            match       <= 1'b0;
            match_count <= '0;
            first_pos   <= '0;
            first_vld   <= 1'b0;
        end else begin
            match <= 1'b0;
            if (start_acc) begin
                pat_q       <= cfg_pattern;
                len_q       <= clamp_len(cfg_len);
                ovl_q       <= cfg_overlap;
                tgt_q       <= cfg_target;
                match_count <= '0;
                first_pos   <= '0;
                first_vld   <= 1'b0;
                pos         <= '0;
            end
            if (byte_acc) begin
                byte_q  <= in_data;
                bit_idx <= IDX_W'(BYTE_W - 1);
            end
            if (feed) begin
                pos     <= pos + 1'b1;
                bit_idx <= bit_idx - 1'b1;
                if (hit) begin
                    match       <= 1'b1;
                    match_count <= cnt_inc;
                    if (!first_vld) begin
                        first_pos <= pos;
                        first_vld <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_pattern_scan_ctrl.sv
// Bench for bit_pattern_scan_ctrl: directed scenarios plus randomized scans
// compared against a bit-window reference model.
module tb_bit_pattern_scan_ctrl;

    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 8;
    localparam int POS_W   = 16;
    localparam int LEN_W   = $clog2(PAT_MAX + 1);

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [PAT_MAX-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic [7:0]         in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic [POS_W-1:0]   first_pos;
    logic               first_vld;
    logic               busy;
    logic               done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] bytes[$];

    always #5 clk = ~clk;

    bit_pattern_scan_ctrl #(
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W),
        .POS_W   (POS_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .match       (match),
        .match_count (match_count),
        .first_pos   (first_pos),
        .first_vld   (first_vld),
        .busy        (busy),
        .done        (done)
    );

    // Runs one scan over 'bytes'. Cycle 0 is the edge that accepts start; with
    // bytes always offered, bit k is fed in cycle 2+9*(k/8)+k%8 and its match
    // pulse shows one cycle later. abort_at/mid_start are cycle numbers or -1.
    task automatic run_scan(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                            input logic [7:0] tgt, input int abort_at, input int mid_start,
                            input string tag);
        int exp_pos[$];
        int obs[$];
        bit hbits[$];
        int run_len, lw, nb, exp_done, exp_acc, exp_cnt, acc, done_cnt, done_cyc, last;
        bit tgt_hit, fin, m;
        nb      = bytes.size();
        lw      = (len > 4'd8) ? 8 : int'(len);
        run_len = 0;
        tgt_hit = 0;
        for (int k = 0; k < nb * 8; k++) begin
            int fc;
            logic [7:0] by;
            fc = 2 + 9 * (k / 8) + k % 8;
            if (abort_at >= 0 && fc > abort_at) break;
            by = bytes[k / 8];
            hbits.push_back(by[7 - k % 8]);
            run_len++;
            if (lw > 0 && run_len >= lw) begin
                m = 1;
                for (int j = 0; j < lw; j++)
                    if (hbits[hbits.size() - 1 - j] != pat[j]) m = 0;
                if (m) begin
                    exp_pos.push_back(k);
                    if (!ovl) run_len = 0;
                    if (tgt != 0 && exp_pos.size() == int'(tgt)) begin
                        tgt_hit = 1;
                        break;
                    end
                end
            end
        end
        exp_cnt = (exp_pos.size() > 255) ? 255 : exp_pos.size();
        if (tgt_hit) begin
            last     = exp_pos[exp_pos.size() - 1];
            exp_done = 3 + 9 * (last / 8) + last % 8;
            exp_acc  = last / 8 + 1;
        end else if (abort_at >= 0) begin
            exp_done = abort_at + 1;
            exp_acc  = 0;
            for (int n = 0; n < nb; n++) if (1 + 9 * n < abort_at) exp_acc++;
        end else begin
            exp_done = 2 + 9 * nb;
            exp_acc  = nb;
        end

        @(negedge clk);
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt; start = 1'b1;
        @(negedge clk);
        // Scramble the config right after start so any un-latched use shows up
        cfg_pattern = ~pat; cfg_len = 4'($urandom); cfg_overlap = ~ovl; cfg_target = 8'($urandom);
        acc = 0; done_cnt = 0; done_cyc = -1; fin = 0;
        for (int cyc = 1; cyc < 9 * nb + 12; cyc++) begin
            start = 1'b0;
            abort = 1'b0;
            if (match) obs.push_back(cyc);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                fin = 1;
                break;
            end
            in_valid = 1'b0;
            if (acc < nb) begin
                in_valid = 1'b1;
                in_data  = bytes[acc];
                if (in_ready) acc++;
            end else if (in_ready && abort_at < 0) begin
                abort = 1'b1;
            end
            if (cyc == mid_start) begin
                start = 1'b1; cfg_pattern = 8'($urandom); cfg_len = 4'($urandom);
            end
            if (cyc == abort_at) abort = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0; abort = 1'b0;

        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout: done never observed (done_cnt=%0d), required done at cycle %0d", tag, done_cnt, exp_done);
        end
        checks++;
        if (done_cyc !== exp_done || done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done: cycle=%0d pulses=%0d, required cycle=%0d pulses=1", tag, done_cyc, done_cnt, exp_done);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s idle-after-done: busy=%b in_ready=%b, required 0 0", tag, busy, in_ready);
        end
        checks++;
        if (acc !== exp_acc) begin
            errors++;
            $display("FAIL %s bytes-accepted: got %0d, required %0d", tag, acc, exp_acc);
        end
        checks++;
        if (obs.size() !== exp_pos.size()) begin
            errors++;
            $display("FAIL %s match-pulses: got %0d, required %0d", tag, obs.size(), exp_pos.size());
        end else begin
            for (int i = 0; i < obs.size(); i++) begin
                int ec;
                ec = 3 + 9 * (exp_pos[i] / 8) + exp_pos[i] % 8;
                checks++;
                if (obs[i] !== ec) begin
                    errors++;
                    $display("FAIL %s match-cycle[%0d]: got %0d, required %0d", tag, i, obs[i], ec);
                end
            end
        end
        checks++;
        if (match_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL %s match_count: got %0d, required %0d", tag, match_count, exp_cnt);
        end
        checks++;
        if (first_vld !== (exp_pos.size() > 0)) begin
            errors++;
            $display("FAIL %s first_vld: got %b, required %b", tag, first_vld, exp_pos.size() > 0);
        end
        if (exp_pos.size() > 0) begin
            checks++;
            if (first_pos !== 16'(exp_pos[0])) begin
                errors++;
                $display("FAIL %s first_pos: got %0d, required %0d", tag, first_pos, exp_pos[0]);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, match, match_count, first_pos, first_vld, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset-state: in_ready=%b match=%b count=%0d first_pos=%0d first_vld=%b busy=%b done=%b, required all 0",
                     in_ready, match, match_count, first_pos, first_vld, busy, done);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_overlap();
        bytes = '{8'hDB};
        run_scan(8'b11011, 4'd5, 1'b1, 8'd0, -1, -1, "overlap_db");
        run_scan(8'b11011, 4'd5, 1'b0, 8'd0, -1, -1, "nonoverlap_db");
    endtask

    task automatic test_target_stop();
        bytes = '{8'hFF, 8'hFF};
        run_scan(8'b11, 4'd2, 1'b1, 8'd3, -1, -1, "target3");
    endtask

    task automatic test_abort_mid();
        bytes = '{8'h00};
        run_scan(8'h01, 4'd1, 1'b1, 8'd0, 4, 3, "abort_shift3");
    endtask

    task automatic test_len_edges();
        bytes = '{8'hFF, 8'h00};
        run_scan(8'hFF, 4'd0, 1'b1, 8'd0, -1, -1, "len0");
        bytes = '{8'hA5};
        run_scan(8'hA5, 4'd12, 1'b1, 8'd0, -1, -1, "len12_clamp");
    endtask

    task automatic test_saturation();
        bytes.delete();
        for (int i = 0; i < 32; i++) bytes.push_back(8'hFF);
        run_scan(8'h01, 4'd1, 1'b1, 8'd0, -1, -1, "count_saturate");
    endtask

    task automatic test_back_to_back_random();
        for (int t = 0; t < 30; t++) begin
            int nb, ab, ms;
            nb = $urandom_range(1, 5);
            bytes.delete();
            for (int i = 0; i < nb; i++) begin
                case ($urandom_range(0, 3))
                    0:       bytes.push_back(8'hFF);
                    1:       bytes.push_back(8'h00);
                    2:       bytes.push_back(8'hA5);
                    default: bytes.push_back(8'($urandom));
                endcase
            end
            ab = -1;
            ms = -1;
            if ($urandom_range(0, 3) == 0)
                ab = 2 + 9 * $urandom_range(0, nb - 1) + $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0)
                ms = 2 + 9 * $urandom_range(0, nb - 1) + $urandom_range(0, 7);
            run_scan(8'($urandom), 4'($urandom_range(0, 12)), 1'($urandom), 8'($urandom_range(0, 3)),
                     ab, ms, "random");
        end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1; cfg_target = 8'd0;
        start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (match_count !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre-reset: match_count=%0d busy=%b, required 4 1", match_count, busy);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({in_ready, match, match_count, first_pos, first_vld, busy, done} !== '0) begin
            errors++;
            $display("FAIL async-reset: in_ready=%b match=%b count=%0d first_pos=%0d first_vld=%b busy=%b done=%b, required all 0",
                     in_ready, match, match_count, first_pos, first_vld, busy, done);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b1;
        bytes = '{8'h20};
        run_scan(8'h01, 4'd1, 1'b0, 8'd0, -1, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_target_stop();
        test_abort_mid();
        test_len_edges();
        test_saturation();
        test_back_to_back_random();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
